// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions for the LED chain transmitter and receiver.
// Contents: 50 MHz pulse timing constants, word width, and the receiver state enum.
// No ports; imported with ws2812_pkg::*.
package ws2812_pkg;

  // Pulse timing in cycles of a 50 MHz clock.
  localparam int WS_T0H     = 20;    // high time of a 0 bit
  localparam int WS_T1H     = 40;    // high time of a 1 bit
  localparam int WS_T_BIT   = 62;    // full bit period
  localparam int WS_T_RESET = 2500;  // low time that latches the chain (50 us)

  // Bits per LED colour word.
  localparam int WS_BITS = 24;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } ws_rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus a rise/fall edge detector.
// Ports: clk, reset (sync, active-high), din (async line) -> lvl (synchronized level),
//        rise / fall (one-cycle strobes, valid in the first cycle the new level is seen on lvl).
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;  // previous synchronized level, for edge detection

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes pulse-width bits into 24-bit words tagged with an index,
// with frame sync on a long low gap. Ports: clk, reset (sync, active-high), data (async line)
// -> rgb/num/valid (decoded word strobe), sync (gap strobe), err (bad pulse / partial word strobe).
// Build option: define WS2812_RX_GLITCH_EN to drop high pulses shorter than T_GLITCH cycles.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int T_THRESH  = 30,
  parameter int T_MAXHIGH = 60,
  parameter int T_RESET   = WS_T_RESET,
  parameter int T_GLITCH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data,
  output logic [23:0] rgb,
  output logic [15:0] num,
  output logic        valid,
  output logic        sync,
  output logic        err
);

  localparam int CW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] THRESH_C  = CW'(T_THRESH);
  localparam logic [CW-1:0] MAXHIGH_C = CW'(T_MAXHIGH);
  localparam logic [CW-1:0] RESET_C   = CW'(T_RESET);
  localparam logic [CW-1:0] GLITCH_C  = CW'(T_GLITCH);
  localparam logic [4:0]    LAST_BIT  = 5'(WS_BITS - 1);

`ifdef WS2812_RX_GLITCH_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic lvl, rise, fall;

  ws2812_rx_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (data),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  ws_rx_state_t          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         save_q, save_d;   // low count at the last rise, restored after a glitch
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic [WS_BITS-2:0]    shift_q, shift_d; // first 23 bits; the 24th completes the word directly
  logic [15:0]           idx_q, idx_d;
  logic [23:0]           rgb_q, rgb_d;
  logic [15:0]           num_q, num_d;
  logic                  valid_q, valid_d;
  logic                  sync_q, sync_d;
  logic                  err_q, err_d;

  logic [CW-1:0] cnt_inc;
  logic          bit_val;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    save_d   = save_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    rgb_d    = rgb_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    sync_d   = 1'b0;
    err_d    = 1'b0;

    // cnt saturates at T_RESET so a long gap produces one sync only.
    cnt_inc = (cnt_q == RESET_C) ? cnt_q : cnt_q + CW'(1);
    bit_val = (cnt_q >= THRESH_C);

    case (state_q)
      WAIT_GAP: begin
        if (lvl) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == RESET_C) begin
            sync_d   = 1'b1;
            state_d  = LOW;
            bitcnt_d = '0;
            idx_d    = '0;
            num_d    = '0;
          end
        end
      end

      LOW: begin
        if (rise) begin
          state_d = HIGH;
          save_d  = cnt_q;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == RESET_C - CW'(1)) begin
            sync_d   = 1'b1;
            err_d    = (bitcnt_q != '0);
            bitcnt_d = '0;
            idx_d    = '0;
            num_d    = '0;
          end
        end
      end

      HIGH: begin
        if (fall) begin
          state_d = LOW;
          if (GLITCH_EN && (cnt_q < GLITCH_C)) begin
            // Spike: resume the interrupted low period as if nothing happened.
            cnt_d = save_q;
          end else begin
            cnt_d   = CW'(1);
            shift_d = {shift_q[WS_BITS-3:0], bit_val};
            if (bitcnt_q == LAST_BIT) begin
              rgb_d    = {shift_q, bit_val};
              valid_d  = 1'b1;
              bitcnt_d = '0;
              num_d    = idx_q;
              idx_d    = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MAXHIGH_C) begin
            // Stuck-high line: drop the word and resynchronise on the next gap.
            err_d    = 1'b1;
            bitcnt_d = '0;
            cnt_d    = '0;
            state_d  = WAIT_GAP;
          end
        end
      end

      default: begin
        state_d = WAIT_GAP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_GAP;
      cnt_q    <= '0;
      save_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      rgb_q    <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      save_q   <= save_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      rgb_q    <= rgb_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
      err_q    <= err_d;
    end
  end

  assign rgb   = rgb_q;
  assign num   = num_q;
  assign valid = valid_q;
  assign sync  = sync_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected strobes, a monitor pops and compares.
// Expected events are {err,sync,valid} patterns plus rgb/num for words.
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        data;
  logic [23:0] rgb;
  logic [15:0] num;
  logic        valid, sync, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  kind;  // {err, sync, valid}
    logic [23:0] rgb;
    logic [15:0] num;
  } ev_t;

  ev_t exp_q[$];

  localparam logic [2:0] K_VALID   = 3'b001;
  localparam logic [2:0] K_SYNC    = 3'b010;
  localparam logic [2:0] K_ERR     = 3'b100;
  localparam logic [2:0] K_ERRSYNC = 3'b110;

  ws2812_rx dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .rgb  (rgb),
    .num  (num),
    .valid(valid),
    .sync (sync),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [23:0] r, input logic [15:0] n);
    ev_t e;
    e.kind = k;
    e.rgb  = r;
    e.num  = n;
    exp_q.push_back(e);
  endtask

  // All line changes happen on the falling edge, held for whole cycles.
  task automatic hold(input logic v, input int n);
    data = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? 40 : 20);
    hold(1'b0, b ? 22 : 42);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic gap();
    hold(1'b0, 3000);
  endtask

  // Monitor: every strobe cycle must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (valid || sync || err) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got err=%0b sync=%0b valid=%0b rgb=%h num=%0d, expected none",
                   err, sync, valid, rgb, num);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {29'd0, err, sync, valid}, {29'd0, e.kind});
          if (e.kind == K_VALID) begin
            chk("rgb", {8'd0, rgb}, {8'd0, e.rgb});
            chk("num", {16'd0, num}, {16'd0, e.num});
          end
        end
      end
    end
  end

  initial begin
    int first_err;
    reset = 1'b1;
    data  = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rgb",   {8'd0, rgb}, 32'd0);
    chk("reset_num",   {16'd0, num}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_sync",  {31'd0, sync}, 32'd0);
    chk("reset_err",   {31'd0, err}, 32'd0);
    reset = 1'b0;

    // 10 us low interrupted by a pulse must not sync; the following long gap does.
    hold(1'b0, 500);
    hold(1'b1, 10);
    push(K_SYNC, '0, '0);
    gap();
    push(K_VALID, 24'hFF0081, 16'd0);
    send_bits(24'hFF0081, 24);

    // Three words in one frame.
    push(K_SYNC, '0, '0);
    gap();
    push(K_VALID, 24'hA5A5A5, 16'd0);
    send_bits(24'hA5A5A5, 24);
    push(K_VALID, 24'h000001, 16'd1);
    send_bits(24'h000001, 24);
    push(K_VALID, 24'h800000, 16'd2);
    send_bits(24'h800000, 24);
    push(K_SYNC, '0, '0);
    gap();

    // Partial word at a gap: err and sync together.
    send_bits(24'hABCDEF, 12);
    push(K_ERRSYNC, '0, '0);
    gap();

    // Over-long high: err in the 62nd cycle after the line rises, later bits ignored.
    push(K_ERR, '0, '0);
    first_err = 0;
    data = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (err && first_err == 0) first_err = i;
    end
    data = 1'b0;
    chk("maxhigh_err_cycle", first_err, 62);
    hold(1'b0, 40);
    send_bits(24'h123456, 5);
    push(K_SYNC, '0, '0);
    gap();

    // Reset mid-word discards it.
    send_bits(24'hFFFFFF, 10);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_rgb",   {8'd0, rgb}, 32'd0);
    chk("midreset_num",   {16'd0, num}, 32'd0);
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_flags", {30'd0, sync, err}, 32'd0);
    reset = 1'b0;
    push(K_SYNC, '0, '0);
    gap();
    push(K_VALID, 24'h3C5AA5, 16'd0);
    send_bits(24'h3C5AA5, 24);
    push(K_SYNC, '0, '0);
    gap();

    // 2-cycle spike in the low time after bit 5 of 00FF00.
`ifdef WS2812_RX_GLITCH_EN
    push(K_VALID, 24'h00FF00, 16'd0);
    push(K_SYNC, '0, '0);
`else
    push(K_VALID, 24'h007F80, 16'd0);
    push(K_ERRSYNC, '0, '0);
`endif
    send_bits(24'h00FF00, 5);
    hold(1'b1, 20);
    hold(1'b0, 10);
    hold(1'b1, 2);
    hold(1'b0, 30);
    for (int i = 17; i >= 0; i--) send_bit(1'(24'h00FF00 >> i));
    gap();

    hold(1'b0, 20);
    chk("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
